bit_serial_alu_ctrl: RTL and testbench
======================================

Name: bit_serial_alu_ctrl

Overview:
Sequencer that runs a WIDTH-bit ALU operation through a single 1-bit ALU slice, one bit per clock, LSB first.
- Bit slice: operand inversion, AND/OR/XOR/NOR, and add with a registered carry.
- The block latches operands, drives the slice op/inversion controls, holds the carry between bits and assembles the result.
- It sits between a requester using a start/done handshake and the bit-level datapath. It is the multi-bit wrapper for our 1-bit ALU slice.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); also the number of RUN cycles per operation.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only when state is IDLE or DONE.
op  input  3  operation code, latched with start.
a  input  WIDTH  operand A, latched with start.
b  input  WIDTH  operand B, latched with start.
busy  output  1  high while state is RUN.
done  output  1  single-cycle pulse: result/carry_out/zero are newly valid.
result  output  WIDTH  last completed result; held until the next completion.
carry_out  output  1  final carry of ADD/SUB; 0 for all other ops.
zero  output  1  high when result == 0; tracks the held result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy, done, result, carry_out=0.
  - zero=1, consistent with result=0.
  - All internal shift registers, bit counter and carry register are cleared.
  - Reset mid-RUN aborts the operation with no done pulse.
- op encoding:
  - 000 AND; 001 OR; 010 XOR; 011 NOR.
  - 100 ADD (A+B, carry-in 0).
  - 101 SUB (A + ~B + 1: Binv=1, carry-in 1).
  - 110/111: result 0, carry_out 0. The op still takes WIDTH cycles and pulses done.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, b, op into shift registers. Set bit counter=0 and carry register = (op==101). Go to RUN.
  - RUN: each edge processes bit i = counter.
    - Slice inputs are the A/B shift-register LSBs, with inversion per op.
    - ADD/SUB: sum bit = a_i ^ b_i' ^ c; next c = majority(a_i, b_i', c).
    - Logic ops use the slice's gate outputs; carry register is held at 0.
    - Result bit is shifted in at the MSB of the internal result shift register; A/B shift right.
    - On the edge where counter == WIDTH-1: copy internal result to result; carry_out = final carry (ADD/SUB) else 0; update zero; go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted exactly as in IDLE, allowing back-to-back ops.
    - Otherwise go to IDLE.
- Latency: start sampled at edge 0 → busy high during cycles 1..WIDTH → done high in cycle WIDTH+1. Outputs are valid from that cycle onward.
- Throughput: one op per WIDTH+1 cycles with back-to-back start.
- start during RUN is ignored, with no queuing. a/b/op changes during RUN have no effect.
- result, carry_out and zero change only on the completion edge. They never show partial values.
- Counter width: clog2(WIDTH). No wrap beyond WIDTH-1.
- SUB carry_out follows carry convention: 1 = no borrow (A>=B unsigned), 0 = borrow.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, rst pulse → result=0x00, carry_out=0, zero=1, busy=0, done=0. Then start with op=100, a=0xFF, b=0x01 → busy for 8 cycles, done in cycle 9 → result=0x00, carry_out=1, zero=1.
- a=0xCA, b=0x53, ops 000/001/010/011 issued back-to-back, each start in the DONE cycle → results 0x42, 0xDB, 0x99, 0x24. carry_out=0 each time; done pulses exactly 9 cycles apart.
- op=101, a=0x05, b=0x07 → result=0xFE, carry_out=0. Then op=101, a=0x07, b=0x05 → result=0x02, carry_out=1, zero=0.
- op=110, a=0xAA, b=0x55 → after 8 busy cycles, result=0x00, carry_out=0, zero=1, done pulses once.
- Start ADD 0x10+0x20. Mid-RUN at cycle 4, assert start with op=000, a=0xFF, b=0xFF and change a/b → ignored; result=0x30 at cycle 9.
- Start ADD 0x7F+0x01. Assert rst asynchronously at cycle 3 (between edges) → outputs clear immediately, no done. A fresh start after reset gives the correct 0x80 with carry_out=0.

Source files
------------

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit operation through a
// single 1-bit slice, LSB first, with a start/done handshake.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic             load, step, last;
  logic [WIDTH-1:0] sh_a, sh_b, sh_r, sh_r_n;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             cy, cy_n;
  logic             bit_a, bit_b, bit_r;
  logic             arith, binv;

  // One-bit slice: optional B inversion, gates, full adder on carry reg
  always_comb begin
    arith = op_q[2] & ~op_q[1];
    binv  = (op_q == 3'b101);
    bit_a = sh_a[0];
    bit_b = sh_b[0] ^ binv;
    bit_r = 1'b0;
    cy_n  = 1'b0;
    unique case (op_q)
      3'b000: bit_r = bit_a & bit_b;
      3'b001: bit_r = bit_a | bit_b;
      3'b010: bit_r = bit_a ^ bit_b;
      3'b011: bit_r = ~(bit_a | bit_b);
      3'b100,
      3'b101: begin
        bit_r = bit_a ^ bit_b ^ cy;
        cy_n  = (bit_a & bit_b) | (bit_a & cy) | (bit_b & cy);
      end
      default: bit_r = 1'b0;
    endcase
    sh_r_n = {bit_r, sh_r[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = (cnt == CW'(WIDTH - 1));
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a      <= '0;
      sh_b      <= '0;
      sh_r      <= '0;
      op_q      <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
    end else if (load) begin
      sh_a <= a;
      sh_b <= b;
      sh_r <= '0;
      op_q <= op;
      cnt  <= '0;
      cy   <= (op == 3'b101);
    end else if (step) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      sh_r <= sh_r_n;
      cy   <= cy_n;
      if (last) begin
        result    <= sh_r_n;
        carry_out <= arith & cy_n;
        zero      <= (sh_r_n == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Randomized self-checking bench for bit_serial_alu_ctrl against an
// arithmetic reference model.
module tb_bit_serial_alu_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, zero;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] held_r;
  logic         held_c;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .carry_out(carry_out),
    .zero(zero)
  );

  function automatic void model(input logic [2:0] o,
                                input logic [W-1:0] x, y,
                                output logic [W-1:0] r,
                                output logic c);
    logic [W:0] s;
    r = '0;
    c = 1'b0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x | y);
      3'd4: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
      end
      3'd5: begin
        r = x - y;
        c = (x >= y);
      end
      default: r = '0;
    endcase
  endfunction

  // Caller is at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int poke,
                        input string name);
    logic [W-1:0] r;
    logic         c;
    logic         ok;
    model(o, x, y, r, c);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == poke) begin
        start = 1'b1;
        op = 3'd0;
        a = '1;
        b = '1;
      end else begin
        start = 1'($urandom_range(0, 1));
        op = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || result !== held_r ||
          carry_out !== held_c)
        ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s run window: busy=%b done=%b result=%h required busy=1 done=0 held %h",
               name, busy, done, result, held_r);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse: done=%b busy=%b required done=1 busy=0",
               name, done, busy);
    end
    checks++;
    if (result !== r || carry_out !== c || zero !== (r == '0)) begin
      errors++;
      $display("FAIL %s outputs: result=%h carry=%b zero=%b required %h %b %b",
               name, result, carry_out, zero, r, c, (r == '0));
    end
    held_r = r;
    held_c = c;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== held_r) begin
      errors++;
      $display("FAIL %s idle: done=%b busy=%b result=%h required 0 0 %h",
               name, done, busy, result, held_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #1 rst = 1'b1;
    #12;
    checks++;
    if (result !== '0 || carry_out !== 1'b0 || zero !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h carry=%b zero=%b busy=%b done=%b required 00 0 1 0 0",
               result, carry_out, zero, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    held_r = '0;
    held_c = 1'b0;
    idle_check("after_reset");
  endtask

  task automatic test_add();
    run_op(3'd4, 8'hFF, 8'h01, -1, "add_ff_01");
    idle_check("add_ff_01");
  endtask

  task automatic test_logic_back_to_back();
    for (int k = 0; k < 4; k++)
      run_op(3'(k), 8'hCA, 8'h53, -1, "logic_b2b");
    idle_check("logic_b2b");
  endtask

  task automatic test_sub();
    run_op(3'd5, 8'h05, 8'h07, -1, "sub_5_7");
    run_op(3'd5, 8'h07, 8'h05, -1, "sub_7_5");
    run_op(3'd5, 8'h33, 8'h33, -1, "sub_eq");
    idle_check("sub");
  endtask

  task automatic test_illegal();
    run_op(3'd4, 8'h0F, 8'h01, -1, "pre_illegal");
    run_op(3'd6, 8'hAA, 8'h55, -1, "op110");
    idle_check("op110");
    run_op(3'd7, 8'hFF, 8'hFF, -1, "op111");
    idle_check("op111");
  endtask

  task automatic test_ignore_start();
    run_op(3'd4, 8'h10, 8'h20, 3, "ignore_start");
    idle_check("ignore_start");
  endtask

  task automatic test_async_reset();
    logic ok;
    run_op(3'd4, 8'hFF, 8'hFF, -1, "pre_reset");
    start = 1'b1;
    op = 3'd4;
    a = 8'h7F;
    b = 8'h01;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (result !== '0 || carry_out !== 1'b0 || zero !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: result=%h carry=%b zero=%b busy=%b done=%b required 00 0 1 0 0",
               result, carry_out, zero, busy, done);
    end
    held_r = '0;
    held_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL async_reset abort: done=%b busy=%b required 0 0",
               done, busy);
    end
    run_op(3'd4, 8'h7F, 8'h01, -1, "post_reset_add");
    idle_check("post_reset_add");
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] x, y;
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = W'($urandom);
      if ((n % 5) == 0) y = x;
      run_op(o, x, y, -1, "random");
      if ($urandom_range(0, 1) == 1) idle_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic_back_to_back();
    test_sub();
    test_illegal();
    test_ignore_start();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end
endmodule
